// File: rtl/cache_access_sequencer.sv
// cache_access_sequencer
// Multi-cycle controller for one access to a 4-way fully-associative,
// write-back, write-allocate cache.  It issues the tag lookup, writes back a
// dirty victim, reads the refill word from a single-port synchronous memory,
// and drives the way fill and LRU touch.  No cache storage lives here.
module cache_access_sequencer #(
    parameter int MEM_LAT = 1,   // memory read latency, 1..3 cycles
    parameter int CNT_W   = 8    // width of the saturating hit/miss counters
) (
    input  logic             Clock,
    input  logic             Reset,
    // requester side
    input  logic             Req,
    input  logic             Write,
    input  logic [6:0]       Tag_Input,
    input  logic [4:0]       BlockIn,
    output logic             Ready,
    output logic             Done,
    output logic [4:0]       BlockOut,
    output logic             hit,
    // cache array side
    output logic [6:0]       C_Tag,
    output logic             C_Lookup,
    input  logic             C_Hit,
    input  logic [1:0]       C_Way,
    input  logic             C_Victim_Valid,
    input  logic             C_Victim_Dirty,
    input  logic [6:0]       C_Victim_Tag,
    input  logic [4:0]       C_Read_Block,
    output logic             C_Fill,
    output logic             C_Touch,
    output logic [1:0]       C_Fill_Way,
    output logic [6:0]       C_Fill_Tag,
    output logic [4:0]       C_Fill_Block,
    output logic             C_Fill_Dirty,
    // memory side
    output logic [6:0]       Tag_Output,
    output logic [4:0]       C_Block_M,
    output logic             C_Write_M,
    input  logic [4:0]       M_Block_C,
    // statistics
    output logic [CNT_W-1:0] Hit_Count,
    output logic [CNT_W-1:0] Miss_Count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_RD,
        S_FILL,
        S_RESP
    } state_t;

    // RD lasts MEM_LAT+1 cycles; the counter's final value marks the capture edge.
    localparam logic [1:0] RD_LAST = 2'(MEM_LAT);

    state_t state_reg, state_next;

    // latched request
    logic       write_reg;
    logic [6:0] tag_reg;
    logic [4:0] block_in_reg;

    // captured lookup results
    logic [1:0] way_reg;
    logic [6:0] victim_tag_reg;
    logic [4:0] wb_data_reg;

    // refill word and memory read timing
    logic [4:0] fetched_reg;
    logic [1:0] rd_cnt_reg;

    // response
    logic [4:0] block_out_reg;
    logic       hit_reg;

    // statistics: index 0 counts hits, index 1 counts misses
    logic [CNT_W-1:0] count_reg [2];
    logic [1:0]       count_inc;

    logic [4:0] fill_block;
    logic       victim_needs_wb;

    assign victim_needs_wb = C_Victim_Valid && C_Victim_Dirty;

    // Writes allocate with the requester's word; reads allocate with the fetched word.
    assign fill_block = write_reg ? block_in_reg : fetched_reg;

    assign C_Tag        = tag_reg;
    assign C_Fill_Way   = way_reg;
    assign C_Fill_Tag   = tag_reg;
    assign C_Fill_Block = fill_block;
    assign C_Fill_Dirty = write_reg;
    assign C_Block_M    = wb_data_reg;
    assign BlockOut     = block_out_reg;
    assign hit          = hit_reg;
    assign Hit_Count    = count_reg[0];
    assign Miss_Count   = count_reg[1];

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection and Moore strobe decode.
    always_comb begin
        state_next = state_reg;
        Ready      = 1'b0;
        Done       = 1'b0;
        C_Lookup   = 1'b0;
        C_Fill     = 1'b0;
        C_Touch    = 1'b0;
        C_Write_M  = 1'b0;
        Tag_Output = tag_reg;

        case (state_reg)
            S_IDLE: begin
                Ready = !Reset;
                if (Req) begin
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                C_Lookup = 1'b1;
                if (C_Hit) begin
                    state_next = write_reg ? S_FILL : S_RESP;
                end else if (victim_needs_wb) begin
                    state_next = S_WB;
                end else begin
                    // one-word blocks: a write miss needs no memory read
                    state_next = write_reg ? S_FILL : S_RD;
                end
            end
            S_WB: begin
                C_Write_M  = 1'b1;
                Tag_Output = victim_tag_reg;
                state_next = write_reg ? S_FILL : S_RD;
            end
            S_RD: begin
                if (rd_cnt_reg == RD_LAST) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                C_Fill     = 1'b1;
                C_Touch    = 1'b1;
                state_next = S_RESP;
            end
            S_RESP: begin
                Done       = 1'b1;
                // a read hit never passes through FILL, so LRU is updated here
                C_Touch    = hit_reg && !write_reg;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request latch, lookup capture, refill capture and response registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            write_reg      <= 1'b0;
            tag_reg        <= '0;
            block_in_reg   <= '0;
            way_reg        <= '0;
            victim_tag_reg <= '0;
            wb_data_reg    <= '0;
            fetched_reg    <= '0;
            rd_cnt_reg     <= '0;
            block_out_reg  <= '0;
            hit_reg        <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (Req) begin
                        write_reg    <= Write;
                        tag_reg      <= Tag_Input;
                        block_in_reg <= BlockIn;
                    end
                end
                S_LOOKUP: begin
                    way_reg    <= C_Way;
                    rd_cnt_reg <= '0;
                    hit_reg    <= C_Hit;
                    if (C_Hit && !write_reg) begin
                        block_out_reg <= C_Read_Block;
                    end
                    if (!C_Hit && victim_needs_wb) begin
                        victim_tag_reg <= C_Victim_Tag;
                        wb_data_reg    <= C_Read_Block;
                    end
                end
                S_RD: begin
                    if (rd_cnt_reg == RD_LAST) begin
                        fetched_reg <= M_Block_C;
                        rd_cnt_reg  <= '0;
                    end else begin
                        rd_cnt_reg <= rd_cnt_reg + 2'd1;
                    end
                end
                S_FILL: begin
                    block_out_reg <= fill_block;
                end
                default: begin
                end
            endcase
        end
    end

    // Hit and miss are both decided in LOOKUP.
    always_comb begin
        count_inc[0] = (state_reg == S_LOOKUP) && C_Hit;
        count_inc[1] = (state_reg == S_LOOKUP) && !C_Hit;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_count
            // Saturating event counter; holds at all-ones instead of wrapping.
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    count_reg[gi] <= '0;
                end else if (count_inc[gi] && (count_reg[gi] != {CNT_W{1'b1}})) begin
                    count_reg[gi] <= count_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_cache_access_sequencer.sv
// Directed bench for cache_access_sequencer: the cache array is driven as
// per-access constants, the memory is a small synchronous RAM model.
module tb_cache_access_sequencer;

    logic       Clock, Reset;
    logic       Req, Write;
    logic [6:0] Tag_Input;
    logic [4:0] BlockIn;
    logic       Ready, Done;
    logic [4:0] BlockOut;
    logic       hit;
    logic [6:0] C_Tag;
    logic       C_Lookup;
    logic       C_Hit;
    logic [1:0] C_Way;
    logic       C_Victim_Valid, C_Victim_Dirty;
    logic [6:0] C_Victim_Tag;
    logic [4:0] C_Read_Block;
    logic       C_Fill, C_Touch;
    logic [1:0] C_Fill_Way;
    logic [6:0] C_Fill_Tag;
    logic [4:0] C_Fill_Block;
    logic       C_Fill_Dirty;
    logic [6:0] Tag_Output;
    logic [4:0] C_Block_M;
    logic       C_Write_M;
    logic [4:0] M_Block_C;
    logic [7:0] Hit_Count, Miss_Count;

    int n_checks = 0;
    int n_fail   = 0;

    cache_access_sequencer #(.MEM_LAT(1), .CNT_W(8)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req(Req), .Write(Write), .Tag_Input(Tag_Input), .BlockIn(BlockIn),
        .Ready(Ready), .Done(Done), .BlockOut(BlockOut), .hit(hit),
        .C_Tag(C_Tag), .C_Lookup(C_Lookup), .C_Hit(C_Hit), .C_Way(C_Way),
        .C_Victim_Valid(C_Victim_Valid), .C_Victim_Dirty(C_Victim_Dirty),
        .C_Victim_Tag(C_Victim_Tag), .C_Read_Block(C_Read_Block),
        .C_Fill(C_Fill), .C_Touch(C_Touch), .C_Fill_Way(C_Fill_Way),
        .C_Fill_Tag(C_Fill_Tag), .C_Fill_Block(C_Fill_Block), .C_Fill_Dirty(C_Fill_Dirty),
        .Tag_Output(Tag_Output), .C_Block_M(C_Block_M), .C_Write_M(C_Write_M),
        .M_Block_C(M_Block_C), .Hit_Count(Hit_Count), .Miss_Count(Miss_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Single-port synchronous RAM, one cycle read latency.
    logic [4:0] mem [0:127];
    always @(posedge Clock) begin
        M_Block_C <= mem[Tag_Output];
        if (C_Write_M) mem[Tag_Output] <= C_Block_M;
    end

    // Observations gathered over one access.
    int         lat, wm_n, fill_n, lookup_n, excl_viol;
    logic [6:0] wm_tag, fill_tag, lookup_tag;
    logic [4:0] wm_data, fill_blk, resp_blk;
    logic [1:0] fill_way, resp_way;
    logic       fill_dirty, fill_touch, resp_touch, resp_hit;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_access(input logic wr, input logic [6:0] tg, input logic [4:0] din,
                             input logic ch, input logic [1:0] cw, input logic vv,
                             input logic vd, input logic [6:0] vt, input logic [4:0] vdat);
        int k;
        @(negedge Clock);
        Write = wr; Tag_Input = tg; BlockIn = din;
        C_Hit = ch; C_Way = cw; C_Victim_Valid = vv; C_Victim_Dirty = vd;
        C_Victim_Tag = vt; C_Read_Block = vdat; Req = 1'b1;
        k = 0;
        while (!Ready && k < 20) begin
            @(negedge Clock);
            k++;
        end
        lat = 0; wm_n = 0; fill_n = 0; lookup_n = 0;
        wm_tag = '0; wm_data = '0; fill_tag = '0; fill_blk = '0; fill_way = '0;
        fill_dirty = 1'b0; fill_touch = 1'b0; lookup_tag = '0;
        resp_touch = 1'b0; resp_way = '0; resp_blk = '0; resp_hit = 1'b0;
        if (!Ready) begin
            check_val("accept_timeout", 32'd0, 32'd1);
            Req = 1'b0;
            return;
        end
        @(negedge Clock);
        Req = 1'b0;
        for (k = 1; k <= 20; k++) begin
            if (C_Write_M && C_Fill) excl_viol++;
            if (C_Lookup) begin
                lookup_n++;
                lookup_tag = C_Tag;
            end
            if (C_Write_M) begin
                wm_n++;
                wm_tag  = Tag_Output;
                wm_data = C_Block_M;
            end
            if (C_Fill) begin
                fill_n++;
                fill_way = C_Fill_Way; fill_tag = C_Fill_Tag; fill_blk = C_Fill_Block;
                fill_dirty = C_Fill_Dirty; fill_touch = C_Touch;
            end
            if (Done) begin
                lat = k;
                resp_touch = C_Touch; resp_way = C_Fill_Way;
                resp_blk = BlockOut; resp_hit = hit;
                break;
            end
            @(negedge Clock);
        end
        if (lat == 0) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dones, gap_err, last_k, first_k;
        for (int i = 0; i < 128; i++) mem[i] = 5'd7;
        mem[103] = 5'd14;
        excl_viol = 0;
        Reset = 1'b1; Req = 1'b0; Write = 1'b0; Tag_Input = '0; BlockIn = '0;
        C_Hit = 1'b0; C_Way = '0; C_Victim_Valid = 1'b0; C_Victim_Dirty = 1'b0;
        C_Victim_Tag = '0; C_Read_Block = '0;
        repeat (3) @(negedge Clock);

        // Reset state
        check_val("rst_ready_held", 32'(Ready), 32'd0);
        check_val("rst_done", 32'(Done), 32'd0);
        check_val("rst_lookup", 32'(C_Lookup), 32'd0);
        check_val("rst_blockout", 32'(BlockOut), 32'd0);
        check_val("rst_hitcnt", 32'(Hit_Count), 32'd0);
        Reset = 1'b0;
        #1;
        check_val("rst_ready", 32'(Ready), 32'd1);

        // Read hit: tag 100, way 0, data 5
        do_access(1'b0, 7'd100, 5'd0, 1'b1, 2'd0, 1'b1, 1'b0, 7'd100, 5'd5);
        $display("read hit tag 100: lat=%0d BlockOut=%0d hit=%0d", lat, resp_blk, resp_hit);
        check_val("rh_lat", 32'(lat), 32'd2);
        check_val("rh_blockout", 32'(resp_blk), 32'd5);
        check_val("rh_hit", 32'(resp_hit), 32'd1);
        check_val("rh_touch", 32'(resp_touch), 32'd1);
        check_val("rh_touch_way", 32'(resp_way), 32'd0);
        check_val("rh_lookup_tag", 32'(lookup_tag), 32'd100);
        check_val("rh_hitcnt", 32'(Hit_Count), 32'd1);
        check_val("rh_no_wm", 32'(wm_n), 32'd0);
        check_val("rh_no_fill", 32'(fill_n), 32'd0);

        // Read miss, clean victim way 2, memory returns 14
        do_access(1'b0, 7'd103, 5'd0, 1'b0, 2'd2, 1'b1, 1'b0, 7'd50, 5'd1);
        $display("read miss clean tag 103: lat=%0d fill way=%0d data=%0d", lat, fill_way, fill_blk);
        check_val("rmc_lat", 32'(lat), 32'd5);
        check_val("rmc_fill_way", 32'(fill_way), 32'd2);
        check_val("rmc_fill_tag", 32'(fill_tag), 32'd103);
        check_val("rmc_fill_blk", 32'(fill_blk), 32'd14);
        check_val("rmc_fill_dirty", 32'(fill_dirty), 32'd0);
        check_val("rmc_hit", 32'(resp_hit), 32'd0);
        check_val("rmc_blockout", 32'(resp_blk), 32'd14);
        check_val("rmc_resp_touch", 32'(resp_touch), 32'd0);
        check_val("rmc_misscnt", 32'(Miss_Count), 32'd1);
        check_val("rmc_no_wm", 32'(wm_n), 32'd0);

        // Read miss, dirty victim way 3 holding tag 101 / data 3
        do_access(1'b0, 7'd103, 5'd0, 1'b0, 2'd3, 1'b1, 1'b1, 7'd101, 5'd3);
        $display("read miss dirty tag 103: lat=%0d wb tag=%0d data=%0d", lat, wm_tag, wm_data);
        check_val("rmd_lat", 32'(lat), 32'd6);
        check_val("rmd_wm_n", 32'(wm_n), 32'd1);
        check_val("rmd_wm_tag", 32'(wm_tag), 32'd101);
        check_val("rmd_wm_data", 32'(wm_data), 32'd3);
        check_val("rmd_fill_blk", 32'(fill_blk), 32'd14);
        check_val("rmd_fill_way", 32'(fill_way), 32'd3);
        check_val("rmd_mem101", 32'(mem[101]), 32'd3);
        check_val("rmd_misscnt", 32'(Miss_Count), 32'd2);

        // Write hit: tag 102, data 9, way 1
        do_access(1'b1, 7'd102, 5'd9, 1'b1, 2'd1, 1'b1, 1'b0, 7'd102, 5'd20);
        $display("write hit tag 102: lat=%0d fill data=%0d dirty=%0d", lat, fill_blk, fill_dirty);
        check_val("wh_lat", 32'(lat), 32'd3);
        check_val("wh_fill_way", 32'(fill_way), 32'd1);
        check_val("wh_fill_blk", 32'(fill_blk), 32'd9);
        check_val("wh_fill_dirty", 32'(fill_dirty), 32'd1);
        check_val("wh_fill_touch", 32'(fill_touch), 32'd1);
        check_val("wh_no_wm", 32'(wm_n), 32'd0);
        check_val("wh_blockout", 32'(resp_blk), 32'd9);
        check_val("wh_hit", 32'(resp_hit), 32'd1);
        check_val("wh_hitcnt", 32'(Hit_Count), 32'd2);

        // Write miss, invalid victim (dirty bit set but invalid: no write-back)
        do_access(1'b1, 7'd104, 5'd17, 1'b0, 2'd0, 1'b0, 1'b1, 7'd60, 5'd2);
        $display("write miss invalid tag 104: lat=%0d wm=%0d", lat, wm_n);
        check_val("wmc_lat", 32'(lat), 32'd3);
        check_val("wmc_no_wm", 32'(wm_n), 32'd0);
        check_val("wmc_fill_blk", 32'(fill_blk), 32'd17);
        check_val("wmc_fill_dirty", 32'(fill_dirty), 32'd1);
        check_val("wmc_hit", 32'(resp_hit), 32'd0);

        // Write miss, dirty victim way 1 with tag 99 / data 30
        do_access(1'b1, 7'd105, 5'd21, 1'b0, 2'd1, 1'b1, 1'b1, 7'd99, 5'd30);
        $display("write miss dirty tag 105: lat=%0d wb tag=%0d data=%0d", lat, wm_tag, wm_data);
        check_val("wmd_lat", 32'(lat), 32'd4);
        check_val("wmd_wm_tag", 32'(wm_tag), 32'd99);
        check_val("wmd_wm_data", 32'(wm_data), 32'd30);
        check_val("wmd_fill_blk", 32'(fill_blk), 32'd21);
        check_val("wmd_fill_tag", 32'(fill_tag), 32'd105);
        check_val("wmd_misscnt", 32'(Miss_Count), 32'd4);
        check_val("excl_wm_fill", 32'(excl_viol), 32'd0);

        // Reset during the second RD cycle of a read miss
        @(negedge Clock);
        Write = 1'b0; Tag_Input = 7'd110; C_Hit = 1'b0; C_Way = 2'd0;
        C_Victim_Valid = 1'b1; C_Victim_Dirty = 1'b0; Req = 1'b1;
        @(negedge Clock);
        Req = 1'b0;
        check_val("ra_lookup", 32'(C_Lookup), 32'd1);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        $display("reset mid-RD: Ready=%0d C_Fill=%0d Hit=%0d Miss=%0d", Ready, C_Fill, Hit_Count, Miss_Count);
        check_val("ra_ready", 32'(Ready), 32'd1);
        check_val("ra_no_fill", 32'(C_Fill), 32'd0);
        check_val("ra_hitcnt", 32'(Hit_Count), 32'd0);
        check_val("ra_misscnt", 32'(Miss_Count), 32'd0);
        check_val("ra_blockout", 32'(BlockOut), 32'd0);
        check_val("ra_hit", 32'(hit), 32'd0);
        check_val("ra_ctag", 32'(C_Tag), 32'd0);
        @(negedge Clock);
        check_val("ra_no_fill_after", 32'(C_Fill), 32'd0);

        // 260 back-to-back read hits with Req held through RESP
        Write = 1'b0; Tag_Input = 7'd100; C_Hit = 1'b1; C_Way = 2'd0;
        C_Read_Block = 5'd5; Req = 1'b1;
        dones = 0; gap_err = 0; last_k = 0; first_k = 0;
        for (int k = 0; k < 1000; k++) begin
            if (Done) begin
                dones++;
                if (first_k == 0) first_k = k;
                else if (k - last_k != 3) gap_err++;
                last_k = k;
                if (dones == 260) begin
                    Req = 1'b0;
                    break;
                end
            end
            @(negedge Clock);
        end
        $display("260 read hits: dones=%0d Hit_Count=%0d gap_err=%0d", dones, Hit_Count, gap_err);
        check_val("sat_dones", 32'(dones), 32'd260);
        check_val("sat_first_lat", 32'(first_k), 32'd2);
        check_val("sat_gap", 32'(gap_err), 32'd0);
        check_val("sat_hitcnt", 32'(Hit_Count), 32'd255);
        check_val("sat_misscnt", 32'(Miss_Count), 32'd0);
        @(negedge Clock);
        check_val("sat_idle_ready", 32'(Ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_access_sequencer.md
Name: cache_access_sequencer

Overview:
- Multi-cycle controller that sequences every circuit access to the 4-way fully-associative, write-back, write-allocate cache.
- Issues the tag lookup, performs victim write-back, issues the memory read for a refill, and drives the way fill and LRU update.
- Sits between the switch/KEY front end, the cache array (tag compare and LRU selection), and the ramlpm single-port synchronous memory.
- Holds no cache storage itself.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from address presented to M_Block_C valid; legal range 1..3.
- CNT_W, 8, width of the saturating hit and miss counters.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  1  access request; sampled only when Ready=1.
- Write  in  1  0 = read, 1 = write; sampled with Req.
- Tag_Input  in  7  access tag; sampled with Req.
- BlockIn  in  5  write data; sampled with Req.
- Ready  out  1  high only in IDLE with Reset low.
- Done  out  1  one-cycle pulse marking access completion.
- BlockOut  out  5  read or written data; registered, held until the next Done.
- hit  out  1  hit/miss of the last access; registered, held until the next Done.
- C_Tag  out  7  latched tag presented to the cache comparators.
- C_Lookup  out  1  high for the single LOOKUP cycle.
- C_Hit  in  1  cache tag match with valid=1; combinational, valid while C_Lookup=1.
- C_Way  in  2  hit way if C_Hit, else LRU victim way.
- C_Victim_Valid  in  1  valid bit of C_Way.
- C_Victim_Dirty  in  1  dirty bit of C_Way.
- C_Victim_Tag  in  7  tag of C_Way.
- C_Read_Block  in  5  data of C_Way.
- C_Fill  out  1  write tag, data, valid=1 and dirty into C_Fill_Way.
- C_Touch  out  1  mark C_Fill_Way as MRU and age the others.
- C_Fill_Way  out  2  way for C_Fill and C_Touch.
- C_Fill_Tag  out  7  tag to write.
- C_Fill_Block  out  5  data to write.
- C_Fill_Dirty  out  1  dirty bit to write.
- Tag_Output  out  7  memory address.
- C_Block_M  out  5  memory write data.
- C_Write_M  out  1  memory write enable, one cycle.
- M_Block_C  in  5  memory read data.
- Hit_Count  out  CNT_W  saturating count of hits.
- Miss_Count  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (wins over everything):
  - State goes to IDLE.
  - All registered outputs go to 0: BlockOut, hit, Hit_Count, Miss_Count, all latched request fields, and the RD counter.
  - All strobes are 0 in the cycle after Reset: Done, C_Lookup, C_Fill, C_Touch, C_Write_M.
- Reset mid-operation aborts with no partial effects; the cache and memory are left as of the last completed strobe.
- States: IDLE, LOOKUP, WB, RD, FILL, RESP. Strobes are Moore outputs decoded from the state.
- IDLE:
  - Ready=1.
  - Req=1 at an edge latches Write, Tag_Input and BlockIn, then moves to LOOKUP.
  - Req while Ready=0 is ignored; the requester must hold Req.
- LOOKUP (1 cycle): C_Lookup=1 and C_Tag=latched tag. Way, victim tag and victim data are captured. Transitions:
  - hit and read: go to RESP with BlockOut=C_Read_Block and hit=1.
  - hit and write: go to FILL with hit=1.
  - miss: hit=0, Miss_Count+1; if victim valid and dirty, go to WB.
  - miss, victim clean or invalid, write: go to FILL (no memory read, since the block is one word).
  - miss, victim clean or invalid, read: go to RD.
  - Hit_Count increments in LOOKUP on any hit.
- WB (1 cycle):
  - Tag_Output=victim tag, C_Block_M=victim data, C_Write_M=1.
  - Then go to FILL if write, RD if read.
- RD (MEM_LAT+1 cycles):
  - Tag_Output=latched tag, C_Write_M=0.
  - An internal counter runs 0..MEM_LAT; M_Block_C is captured on the edge ending count MEM_LAT.
  - Then go to FILL.
- FILL (1 cycle):
  - C_Fill=1 and C_Touch=1; C_Fill_Way=captured way; C_Fill_Tag=latched tag.
  - C_Fill_Block=BlockIn if write, else fetched data; C_Fill_Dirty=Write.
  - BlockOut=C_Fill_Block. Then go to RESP.
- RESP (1 cycle):
  - Done=1 and Ready=0.
  - C_Touch=1 only when the access was a read hit.
  - Then go to IDLE. A Req in RESP is accepted in the following IDLE cycle.
- Latency from the accept edge to the Done cycle (MEM_LAT=1):
  - read hit: 2 cycles.
  - write hit: 3 cycles.
  - write miss, clean victim: 3 cycles; dirty victim: 4 cycles.
  - read miss, clean victim: 5 cycles; dirty victim: 6 cycles.
- Mutual exclusion: C_Write_M and C_Fill are never both high. C_Lookup is never high outside LOOKUP.
- Counters saturate at 2^CNT_W−1 with no wrap.
- Outside WB and RD, Tag_Output=latched tag and C_Block_M holds its last value.

Test Plan:
- Reset, then read tag 100 with cache reporting hit, way 0, data 5 -> Done 2 cycles after accept; BlockOut=5, hit=1, C_Touch in RESP with way 0; Hit_Count=1; no C_Write_M.
- Read tag 103, miss, victim way 2 clean, memory returns 14 -> RD lasts 2 cycles; FILL way 2, tag 103, data 14, dirty 0; Done at accept+5; hit=0; Miss_Count=1.
- Read tag 103, miss, victim way 3 dirty with tag 101, data 3 -> WB cycle with Tag_Output=101, C_Block_M=3, C_Write_M=1; then RD on address 103; Done at accept+6.
- Write tag 102, data 9, hit way 1 -> FILL way 1, data 9, dirty 1, C_Touch=1; no memory access; Done at accept+3; BlockOut=9.
- Reset asserted during the second RD cycle -> next cycle IDLE, Ready=1, no C_Fill; counters and BlockOut=0.
- 260 consecutive read hits with CNT_W=8 -> Hit_Count saturates at 255; Req held during RESP is accepted the next cycle.
